// File: rtl/viterbi_frame_scheduler.sv
// Shares one serial Viterbi decoder between two requesters: round-robin grant, symbol load, start, bit drain into bytes.
// Symbol path and read_ack are combinational; the byte stream holds while out_ready is low and stalls decoder draining.
module viterbi_frame_scheduler #(
  parameter int MAX_FRAME = 64,
  parameter int TIMEOUT   = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  input  logic       in_valid,
  input  logic [1:0] in_sym,
  input  logic       in_last,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_byte,
  output logic [3:0] out_nbits,
  output logic       out_last,
  output logic       out_owner,
  input  logic       out_ready,
  output logic       dec_rx_valid,
  output logic [1:0] dec_rx_sym,
  output logic       dec_start,
  output logic       dec_read_ack,
  output logic       dec_rst_n,
  input  logic       dec_rx_ready,
  input  logic       dec_out_valid,
  input  logic       dec_out_bit,
  input  logic       dec_busy,
  input  logic       dec_frame_done,
  output logic       err_trunc,
  output logic       err_timeout
);
  localparam int SCW = $clog2(MAX_FRAME + 1);
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DRAIN, RELEASE, REL_WAIT} state_t;
  state_t state, state_nxt;

  logic [1:0]     gnt_r;
  logic           owner, ptr;
  logic [SCW-1:0] sym_cnt;
  logic [WDW-1:0] wd_cnt;
  logic [1:0]     wd_rst_cnt;
  logic [7:0]     pack;
  logic [3:0]     bit_cnt;
  logic           ov, last_r;

  logic ready_c, accept, trunc_hit, progress, timeout_hit, wd_rst;
  logic pack_full, done_only, capture, hs, last_c, pick1, rel_ok;

  always_comb begin
    ready_c     = (state == LOAD) && dec_rx_ready && (sym_cnt < SCW'(MAX_FRAME));
    accept      = in_valid && ready_c;
    trunc_hit   = accept && !in_last && (sym_cnt == SCW'(MAX_FRAME - 1));
    progress    = dec_out_valid || dec_frame_done;
    timeout_hit = (state == WAIT) && !progress && (wd_cnt == WDW'(TIMEOUT - 1));
    wd_rst      = (wd_rst_cnt != 2'd0);
    pack_full   = (bit_cnt == 4'd8);
    done_only   = dec_frame_done && !dec_out_valid;
    capture     = (state == DRAIN) && dec_out_valid && !pack_full && !ov;
    hs          = (state == DRAIN) && ov && out_ready;
    // A full byte becomes the frame's last once the decoder reports done with nothing left.
    last_c      = last_r || (ov && done_only);
    pick1       = req[1] && (!req[0] || ptr);
    rel_ok      = dec_rx_ready && !dec_busy && !wd_rst;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (|req) state_nxt = LOAD;
      LOAD:     if (accept && (in_last || sym_cnt == SCW'(MAX_FRAME - 1))) state_nxt = START;
      START:    state_nxt = WAIT;
      WAIT:     if (progress) state_nxt = DRAIN;
                else if (timeout_hit) state_nxt = REL_WAIT;
      DRAIN:    if ((hs && last_c) || (!ov && bit_cnt == 4'd0 && done_only)) state_nxt = RELEASE;
      RELEASE:  state_nxt = REL_WAIT;
      REL_WAIT: if (rel_ok) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt          = gnt_r;
    in_ready     = ready_c;
    dec_rx_valid = accept;
    dec_rx_sym   = (state == LOAD) ? in_sym : 2'b00;
    dec_start    = (state == START) || (state == RELEASE);
    dec_read_ack = capture;
    dec_rst_n    = rst_n && !wd_rst;
    out_valid    = ov;
    out_byte     = pack;
    out_nbits    = ov ? bit_cnt : 4'd0;
    out_last     = ov && last_c;
    out_owner    = owner;
    err_trunc    = trunc_hit;
    err_timeout  = timeout_hit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_r      <= 2'b00;
      owner      <= 1'b0;
      ptr        <= 1'b0;
      sym_cnt    <= '0;
      wd_cnt     <= '0;
      wd_rst_cnt <= 2'd0;
      pack       <= 8'd0;
      bit_cnt    <= 4'd0;
      ov         <= 1'b0;
      last_r     <= 1'b0;
    end else begin
      if (state == IDLE && |req) begin
        gnt_r   <= pick1 ? 2'b10 : 2'b01;
        owner   <= pick1;
        sym_cnt <= '0;
      end
      if (accept) sym_cnt <= sym_cnt + 1'b1;

      if (state == START)     wd_cnt <= '0;
      else if (state == WAIT) wd_cnt <= wd_cnt + 1'b1;
      if (timeout_hit)        wd_rst_cnt <= 2'd2;
      else if (wd_rst)        wd_rst_cnt <= wd_rst_cnt - 1'b1;

      if (capture) begin
        pack[bit_cnt[2:0]] <= dec_out_bit;
        bit_cnt            <= bit_cnt + 1'b1;
        if (bit_cnt == 4'd7) ov <= 1'b1;
      end else if (state == DRAIN && !ov && bit_cnt != 4'd0 && done_only) begin
        ov     <= 1'b1;
        last_r <= 1'b1;
      end
      // Latch the last flag so it stays put while the consumer stalls.
      if (state == DRAIN && ov && done_only) last_r <= 1'b1;
      if (hs || timeout_hit) begin
        pack    <= 8'd0;
        bit_cnt <= 4'd0;
        ov      <= 1'b0;
        last_r  <= 1'b0;
      end

      if (state == REL_WAIT && rel_ok) begin
        gnt_r <= 2'b00;
        ptr   <= !owner;
      end
    end
  end
endmodule
